// File: rtl/spi_l2_rx_sched_if.sv
`timescale 1ns/1ps
// Signal bundle of the SPI layer-2 receive scheduler: command request, SPI pins,
// receive-datapath control and the valid/ready byte output.
interface spi_l2_rx_sched_if;
    logic       start;
    logic [7:0] byte_num;
    logic       busy;
    logic       done;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       rx_work_en;
    logic       rx_work_pulse;
    logic [7:0] rx_byte;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        input  start, byte_num, rx_byte, out_ready,
        output busy, done, spi_cs_n, spi_sclk, rx_work_en, rx_work_pulse, out_data, out_valid
    );

    modport slave (
        output start, byte_num, rx_byte, out_ready,
        input  busy, done, spi_cs_n, spi_sclk, rx_work_en, rx_work_pulse, out_data, out_valid
    );
endinterface

// File: rtl/spi_l2_rx_sched.sv
`timescale 1ns/1ps
// SPI mode-0 N-byte read scheduler: frames CS_n/SCLK, paces the receive datapath and
// hands each byte out through a single-entry valid/ready register. Optional macro: SPI_RX_ABORT_EN.
module spi_l2_rx_sched #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef SPI_RX_ABORT_EN
    input  logic               abort,
`endif
    spi_l2_rx_sched_if.master  bus
);

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HALF_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_WAIT     = 3'd4,
        ST_TEARDOWN = 3'd5
    } state_t;

    state_t     state_q,      state_d;
    logic [7:0] timer_q,      timer_d;
    logic [2:0] bit_cnt_q,    bit_cnt_d;
    logic [7:0] remaining_q,  remaining_d;
    logic       cs_n_q,       cs_n_d;
    logic       sclk_q,       sclk_d;
    logic       work_en_q,    work_en_d;
    logic       work_pulse_q, work_pulse_d;
    logic       busy_q,       busy_d;
    logic       done_q,       done_d;
    logic [7:0] out_data_q,   out_data_d;
    logic       out_valid_q,  out_valid_d;

    logic       out_free_s;
    logic       abort_hit_s;

    // The register is free when empty or being handed off this cycle.
    assign out_free_s = (~out_valid_q) | out_ready_s();

`ifdef SPI_RX_ABORT_EN
    assign abort_hit_s = abort & (state_q != ST_IDLE) & (state_q != ST_TEARDOWN);
`else
    assign abort_hit_s = 1'b0;
`endif

    function automatic logic out_ready_s();
        return bus.out_ready;
    endfunction

    // Next-state, counters and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        remaining_d  = remaining_q;
        cs_n_d       = cs_n_q;
        sclk_d       = sclk_q;
        work_pulse_d = 1'b0;
        done_d       = 1'b0;
        out_data_d   = out_data_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (abort_hit_s) begin
            // Drop the partial byte; a byte completing this very cycle is still kept.
            state_d = ST_TEARDOWN;
            timer_d = 8'd0;
            sclk_d  = 1'b0;
            if (state_q == ST_CAPTURE) begin
                out_data_d  = bus.rx_byte;
                out_valid_d = 1'b1;
            end else begin
                out_data_d  = out_data_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && (bus.byte_num != 8'd0)) begin
                        state_d     = ST_SETUP;
                        remaining_d = bus.byte_num;
                        cs_n_d      = 1'b0;
                        timer_d     = 8'd0;
                    end else if (bus.start) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (timer_q == SETUP_LAST) begin
                        state_d   = ST_SHIFT;
                        timer_d   = 8'd0;
                        bit_cnt_d = 3'd0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (timer_q == HALF_LAST) begin
                        timer_d = 8'd0;
                        sclk_d  = ~sclk_q;
                        if (!sclk_q) begin
                            work_pulse_d = 1'b1;
                            bit_cnt_d    = bit_cnt_q + 3'd1;
                        end else if (bit_cnt_q == 3'd0) begin
                            // Counter wrapped after eight rises: this is the eighth fall.
                            state_d = ST_CAPTURE;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                ST_CAPTURE: begin
                    out_data_d  = bus.rx_byte;
                    out_valid_d = 1'b1;
                    remaining_d = remaining_q - 8'd1;
                    timer_d     = 8'd0;
                    bit_cnt_d   = 3'd0;
                    // The new byte occupies the register; keep shifting only if the consumer takes it.
                    if (remaining_q == 8'd1) begin
                        state_d = ST_TEARDOWN;
                    end else if (bus.out_ready) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (out_free_s) begin
                        state_d = ST_SHIFT;
                        timer_d = 8'd0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_TEARDOWN: begin
                    if (timer_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        cs_n_d  = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                    sclk_d  = 1'b0;
                    timer_d = 8'd0;
                end
            endcase
        end

        work_en_d = (state_d == ST_SHIFT);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers; reset returns every output to its idle value at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            remaining_q  <= 8'd0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            work_en_q    <= 1'b0;
            work_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_data_q   <= 8'd0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            remaining_q  <= remaining_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            work_en_q    <= work_en_d;
            work_pulse_q <= work_pulse_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.spi_cs_n      = cs_n_q;
    assign bus.spi_sclk      = sclk_q;
    assign bus.rx_work_en    = work_en_q;
    assign bus.rx_work_pulse = work_pulse_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_valid     = out_valid_q;

endmodule
